// File: rtl/free_list_allocator_if.sv
// Allocation, free, chain-splice and link-write signals of the free-list
// allocator; master is the client, slave is the allocator.
interface free_list_allocator_if #(
  parameter int ADDR = 4
);
  logic            alloc_valid;
  logic [ADDR-1:0] alloc_addr;
  logic            alloc_pop;
  logic            free_valid;
  logic            free_ready;
  logic [ADDR-1:0] free_addr;
  logic            chain_valid;
  logic            chain_ready;
  logic [ADDR-1:0] chain_head;
  logic [ADDR-1:0] chain_second;
  logic [ADDR-1:0] chain_tail;
  logic [ADDR:0]   chain_len;
  logic            link_we;
  logic [ADDR-1:0] link_addr;
  logic [ADDR-1:0] link_data;

  modport master (
    input  alloc_valid, alloc_addr, free_ready, chain_ready,
    output alloc_pop, free_valid, free_addr,
    output chain_valid, chain_head, chain_second, chain_tail, chain_len,
    output link_we, link_addr, link_data
  );

  modport slave (
    output alloc_valid, alloc_addr, free_ready, chain_ready,
    input  alloc_pop, free_valid, free_addr,
    input  chain_valid, chain_head, chain_second, chain_tail, chain_len,
    input  link_we, link_addr, link_data
  );
endinterface

// File: rtl/free_list_allocator.sv
// Linked free-list allocator over a next-pointer RAM with prefetched head link.
// Define FREE_LIST_STATS_EN to enable the min_free low-watermark register.
module free_list_allocator #(
  parameter int ADDR      = 4,
  parameter int DEPTH     = 16,
  parameter int DIRECTION = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  free_list_allocator_if.slave  bus,
  output logic [ADDR:0]         free_count,
  output logic                  busy,
  output logic [ADDR:0]         min_free
);

  typedef enum logic {INIT, RUN} state_t;

  localparam bit              FWD   = (DIRECTION == 1);
  localparam logic [ADDR-1:0] LAST  = ADDR'(DEPTH - 1);
  localparam logic [ADDR-1:0] HEAD0 = FWD ? '0 : LAST;
  localparam logic [ADDR-1:0] NXT0  = FWD ? ADDR'(1) : ADDR'(DEPTH - 2);
  localparam logic [ADDR-1:0] TAIL0 = FWD ? LAST : '0;
  localparam logic [ADDR:0]   FULL  = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0]   ONE   = (ADDR+1)'(1);

  state_t          state_q, state_d;
  logic [ADDR-1:0] idx_q, idx_d;
  logic [ADDR-1:0] head_q, head_d;
  logic [ADDR-1:0] nxt_q, nxt_d;
  logic [ADDR-1:0] tail_q, tail_d;
  logic [ADDR:0]   count_q, count_d;
  logic            rd_pend_q, rd_pend_d;

  logic [ADDR-1:0] mem [DEPTH];
  logic [ADDR-1:0] rd_data;
  logic            we, re;
  logic [ADDR-1:0] waddr, wdata, raddr;

  logic            run, pop_fire, free_acc, chain_acc, full, push_any;
  logic [ADDR-1:0] nxt_eff, p_head, p_tail, init_data;
  logic [ADDR:0]   p_len;
  logic [ADDR+1:0] sum;
  logic [ADDR:0]   count_sat;

  assign run        = (state_q == RUN);
  assign busy       = (state_q == INIT);
  assign free_count = count_q;

  assign nxt_eff         = rd_pend_q ? rd_data : nxt_q;
  assign bus.alloc_valid = run && (count_q != '0);
  assign bus.alloc_addr  = head_q;
  assign bus.chain_ready = run && !bus.link_we;
  assign bus.free_ready  = run && !bus.link_we && !bus.chain_valid;

  assign pop_fire  = bus.alloc_pop && bus.alloc_valid;
  assign chain_acc = bus.chain_valid && bus.chain_ready;
  assign free_acc  = bus.free_valid && bus.free_ready;
  assign full      = (count_q == FULL);
  // A push into a full list without a simultaneous pop is dropped.
  assign push_any  = (chain_acc || free_acc) && !(full && !pop_fire);

  assign p_head = chain_acc ? bus.chain_head : bus.free_addr;
  assign p_tail = chain_acc ? bus.chain_tail : bus.free_addr;
  assign p_len  = chain_acc ? bus.chain_len : ONE;

  assign sum = {1'b0, count_q}
             + (push_any ? {1'b0, p_len} : '0)
             - {{(ADDR+1){1'b0}}, pop_fire};
  assign count_sat = (sum > {1'b0, FULL}) ? FULL : sum[ADDR:0];

  assign init_data = FWD ? ((idx_q == LAST) ? '0 : idx_q + 1'b1)
                         : ((idx_q == '0) ? LAST : idx_q - 1'b1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    head_d    = head_q;
    nxt_d     = nxt_q;
    tail_d    = tail_q;
    count_d   = count_q;
    rd_pend_d = rd_pend_q;
    we        = 1'b0;
    waddr     = idx_q;
    wdata     = init_data;
    re        = 1'b0;
    raddr     = nxt_eff;
    unique case (state_q)
      INIT: begin
        we    = 1'b1;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d   = RUN;
          idx_d     = '0;
          head_d    = HEAD0;
          nxt_d     = NXT0;
          tail_d    = TAIL0;
          count_d   = FULL;
          rd_pend_d = 1'b0;
        end
      end
      RUN: begin
        if (bus.link_we) begin
          we    = 1'b1;
          waddr = bus.link_addr;
          wdata = bus.link_data;
        end else if (push_any) begin
          we    = 1'b1;
          waddr = tail_q;
          wdata = p_head;
        end
        if (rd_pend_q) begin
          nxt_d     = rd_data;
          rd_pend_d = 1'b0;
        end
        count_d = count_sat;
        if (push_any) tail_d = p_tail;
        if (pop_fire && push_any && count_q == ONE) begin
          head_d = p_head;
          if (chain_acc) nxt_d = bus.chain_second;
        end else if (pop_fire) begin
          head_d    = nxt_eff;
          re        = 1'b1;
          rd_pend_d = 1'b1;
        end else if (push_any && count_q == '0) begin
          head_d = p_head;
          if (chain_acc) nxt_d = bus.chain_second;
        end else if (push_any && count_q == ONE) begin
          nxt_d = p_head;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= INIT;
      idx_q     <= '0;
      head_q    <= '0;
      nxt_q     <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      head_q    <= head_d;
      nxt_q     <= nxt_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // Write-first: a read of the address written this cycle sees the new link.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rd_data <= (we && waddr == raddr) ? wdata : mem[raddr];
  end

`ifdef FREE_LIST_STATS_EN
  logic [ADDR:0] min_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      min_q <= '0;
    end else if (state_q == INIT && idx_q == LAST) begin
      min_q <= FULL;
    end else if (run && count_q < min_q) begin
      min_q <= count_q;
    end
  end

  assign min_free = min_q;
`else
  assign min_free = '0;
`endif

endmodule

// File: tb/tb_free_list_allocator.sv
// Scoreboard bench for free_list_allocator: a queue model of the free list
// predicts every allocated address and the free count.
module tb_free_list_allocator;
  localparam int ADDR  = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [ADDR:0] free_count;
  logic          busy;
  logic [ADDR:0] min_free;

  free_list_allocator_if #(.ADDR(ADDR)) bus ();

  free_list_allocator #(
    .ADDR(ADDR), .DEPTH(DEPTH), .DIRECTION(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave),
    .free_count(free_count),
    .busy(busy),
    .min_free(min_free)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int cq[$];

  task automatic chk(string tag, logic [31:0] got, int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic idle();
    bus.alloc_pop    = 1'b0;
    bus.free_valid   = 1'b0;
    bus.free_addr    = '0;
    bus.chain_valid  = 1'b0;
    bus.chain_head   = '0;
    bus.chain_second = '0;
    bus.chain_tail   = '0;
    bus.chain_len    = '0;
    bus.link_we      = 1'b0;
    bus.link_addr    = '0;
    bus.link_data    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pop_chk(string tag);
    int w;
    chk({tag, "_valid"}, bus.alloc_valid, 1);
    w = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    chk(tag, bus.alloc_addr, w);
  endtask

  task automatic do_op(bit pop, bit fv, int fa);
    if (pop) pop_chk("pop_addr");
    bus.alloc_pop  = pop;
    bus.free_valid = fv;
    bus.free_addr  = ADDR'(fa);
    if (fv && exp_q.size() < DEPTH) exp_q.push_back(fa);
    tick();
    idle();
  endtask

  task automatic do_chain(bit pop, input int el[$]);
    if (pop) pop_chk("chain_pop_addr");
    bus.alloc_pop    = pop;
    bus.chain_valid  = 1'b1;
    bus.chain_head   = ADDR'(el[0]);
    bus.chain_second = ADDR'((el.size() > 1) ? el[1] : el[0]);
    bus.chain_tail   = ADDR'(el[el.size()-1]);
    bus.chain_len    = (ADDR+1)'(el.size());
    foreach (el[i]) exp_q.push_back(el[i]);
    tick();
    idle();
  endtask

  task automatic link(int a, int d);
    bus.link_we   = 1'b1;
    bus.link_addr = ADDR'(a);
    bus.link_data = ADDR'(d);
    tick();
    idle();
  endtask

  task automatic wait_init();
    int cycles = 0;
    while (busy && cycles < 100) begin
      tick();
      cycles++;
    end
    chk("init_cycles", cycles, DEPTH);
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(i);
  endtask

  task automatic reset_chk(string tag);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_valid"}, bus.alloc_valid, 0);
    chk({tag, "_free_ready"}, bus.free_ready, 0);
    chk({tag, "_chain_ready"}, bus.chain_ready, 0);
    chk({tag, "_count"}, free_count, 0);
    chk({tag, "_addr"}, bus.alloc_addr, 0);
    chk({tag, "_min"}, min_free, 0);
  endtask

  initial begin
    int want_min;
    idle();
    #12;
    reset_chk("rst");
    @(negedge clk);
    reset_n = 1'b1;
    wait_init();
    chk("init_valid", bus.alloc_valid, 1);
    chk("init_addr", bus.alloc_addr, 0);
    chk("init_count", free_count, DEPTH);

    for (int i = 0; i < DEPTH; i++) do_op(1'b1, 1'b0, 0);
    chk("drain_valid", bus.alloc_valid, 0);
    chk("drain_count", free_count, 0);

    do_op(1'b0, 1'b1, 5);
    chk("free5_addr", bus.alloc_addr, 5);
    chk("free5_count", free_count, 1);
    do_op(1'b1, 1'b1, 9);
    chk("popfree9_addr", bus.alloc_addr, 9);
    chk("popfree9_count", free_count, 1);
    do_op(1'b1, 1'b0, 0);
    chk("empty_count", free_count, 0);

    link(3, 7);
    link(7, 2);
    cq = {3, 7, 2};
    do_chain(1'b0, cq);
    chk("chain_count", free_count, 3);
    for (int i = 0; i < 3; i++) begin
      do_op(1'b1, 1'b0, 0);
      chk("chain_drain_count", free_count, exp_q.size());
    end

    do_op(1'b0, 1'b1, 4);
    do_op(1'b0, 1'b1, 11);
    do_op(1'b1, 1'b1, 6);
    chk("bypass_count", free_count, 2);
    do_op(1'b1, 1'b0, 0);
    do_op(1'b1, 1'b0, 0);
    chk("bypass_empty", free_count, 0);

    do_op(1'b0, 1'b1, 13);
    link(1, 8);
    cq = {1, 8};
    do_chain(1'b1, cq);
    chk("popchain_count", free_count, 2);
    do_op(1'b1, 1'b0, 0);
    do_op(1'b1, 1'b0, 0);
    chk("popchain_empty", free_count, 0);

    chk("idle_free_ready", bus.free_ready, 1);
    bus.link_we     = 1'b1;
    bus.chain_valid = 1'b1;
    #1;
    chk("link_blocks_free", bus.free_ready, 0);
    chk("link_blocks_chain", bus.chain_ready, 0);
    bus.link_we = 1'b0;
    #1;
    chk("chain_blocks_free", bus.free_ready, 0);
    chk("chain_ready", bus.chain_ready, 1);
    idle();
    @(negedge clk);

    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_init();
    for (int i = 0; i < 4; i++) do_op(1'b1, 1'b0, 0);
    chk("pre_reset_addr", bus.alloc_addr, 4);
    reset_n = 1'b0;
    #1;
    reset_chk("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    wait_init();
    chk("rerun_addr", bus.alloc_addr, 0);
    chk("rerun_count", free_count, DEPTH);

    do_op(1'b0, 1'b1, 3);
    chk("sat_count", free_count, DEPTH);
    chk("sat_addr", bus.alloc_addr, 0);

    for (int i = 0; i < 10; i++) do_op(1'b1, 1'b0, 0);
    chk("ten_pop_count", free_count, 6);
    for (int i = 0; i < 10; i++) do_op(1'b0, 1'b1, i);
    chk("refill_count", free_count, DEPTH);
`ifdef FREE_LIST_STATS_EN
    want_min = 6;
`else
    want_min = 0;
`endif
    chk("min_free", min_free, want_min);
    for (int i = 0; i < DEPTH; i++) do_op(1'b1, 1'b0, 0);
    chk("final_count", free_count, 0);
    chk("final_valid", bus.alloc_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/free_list_allocator.md
FREE_LIST_ALLOCATOR -- requirements
Module: free_list_allocator

Interface
REQ-001 SHALL have parameter ADDR, default 4: address width; 2 <= DEPTH <= 2**ADDR.
REQ-002 SHALL have parameter DEPTH, default 16: number of managed entries.
REQ-003 SHALL have parameter DIRECTION, default 1: initial link order, +1 or -1, taken mod DEPTH.
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 alloc_valid  out  1  alloc_addr holds a free entry.
REQ-007 alloc_addr  out  ADDR  current list head.
REQ-008 alloc_pop  in  1  consumes alloc_addr; ignored unless alloc_valid.
REQ-009 free_valid / free_ready  in / out  1  push a single entry.
REQ-010 free_addr  in  ADDR  entry returned by a single push.
REQ-011 chain_valid / chain_ready  in / out  1  splice a pre-linked chain.
REQ-012 chain_head, chain_second, chain_tail  in  ADDR  first, second, last entry of the chain.
REQ-013 chain_len  in  ADDR+1  chain length, 1..DEPTH.
REQ-014 link_we, link_addr, link_data  in  1, ADDR, ADDR  user write of next[link_addr] = link_data.
REQ-015 free_count  out  ADDR+1  free entries.
REQ-016 busy  out  1  initialisation in progress.
REQ-017 min_free  out  ADDR+1  low-watermark statistic (see Configuration).

Function
REQ-018 SHALL hold a DEPTH x ADDR next-pointer RAM with one synchronous read and one write per cycle, and registers head, nxt (prefetched next[head]), tail, count, rd_pending.
REQ-019 SHALL run FSM INIT -> RUN; INIT writes next[i] = (i+DIRECTION) mod DEPTH at init cycle i, i = 0..DEPTH-1, then enters RUN.
REQ-020 On INIT exit: head = 0 (DIRECTION=1) or DEPTH-1 (DIRECTION=-1); nxt = head+DIRECTION; tail = head-DIRECTION; count = DEPTH.
REQ-021 In INIT: busy=1; alloc_valid, free_ready and chain_ready = 0; link_we ignored.
REQ-022 alloc_valid = RUN && count != 0; alloc_addr = head, combinational from registers.
REQ-023 Pop: head <= nxt_eff; read next[nxt_eff] is issued; nxt_eff = rd_pending ? RAM output : nxt; sustained one pop per cycle SHALL yield the list in order.
REQ-024 Write priority, one write per cycle: link_we > chain > free; chain_ready = RUN && !link_we; free_ready = RUN && !link_we && !chain_valid.
REQ-025 Push (free accepted): write next[tail] = free_addr; tail <= free_addr; count+1; if count==0, head <= free_addr; if count==1, nxt <= free_addr.
REQ-026 Chain accepted: write next[tail] = chain_head; tail <= chain_tail; count + chain_len; if count==0, head <= chain_head and nxt <= chain_second.
REQ-027 Chain accepted with count==1: nxt <= chain_head.
REQ-028 Pop with push/chain: count += pushed-1; at count==1, head <= pushed head, nxt <= chain_second (chain) and tail <= new tail.
REQ-029 A RAM read of an address written the same cycle SHALL return the new data (write-first bypass).
REQ-030 count SHALL saturate at DEPTH; a push at count==DEPTH SHALL be dropped, with no state change.
REQ-031 pop, push and chain with alloc_valid=0 and count==0: pop ignored, push/chain served as in REQ-025/026.

Reset
REQ-032 reset_n low SHALL immediately force state INIT, init index 0, busy=1, alloc_valid=0, free_ready=0, chain_ready=0, free_count=0, alloc_addr=0, min_free=0, rd_pending=0.
REQ-033 Reset mid-operation SHALL discard the list; INIT reruns fully after release; RAM contents need no reset.

Configuration
REQ-034 Macro FREE_LIST_STATS_EN defined: min_free <= min(min_free, free_count) each RUN cycle, loaded with DEPTH on INIT exit.
REQ-035 Macro undefined: min_free tied to 0, no statistic register; all other behaviour identical.

Verification (ADDR=4, DEPTH=16, DIRECTION=1)
REQ-036 Release reset -> busy=1 for 16 cycles, then alloc_valid=1, alloc_addr=0, free_count=16.
REQ-037 16 back-to-back pops -> alloc_addr 0,1,...,15 on consecutive cycles; then alloc_valid=0, free_count=0.
REQ-038 Empty list, free 5 -> next cycle alloc_addr=5, count=1; pop plus free 9 same cycle -> alloc_addr=9, count=1.
REQ-039 Empty list; link writes 3->7, 7->2; chain 3/7/2, len 3 -> pops return 3, 7, 2; count 3 -> 0.
REQ-040 reset_n low after 4 pops -> outputs cleared without a clock edge; after release, 16 INIT cycles, alloc_addr=0.
REQ-041 FREE_LIST_STATS_EN: 10 pops then 10 frees -> min_free=6, free_count=16; undefined -> min_free=0.
